// File: rtl/uart_rx_param.sv
// uart_rx_param: parameterised UART receiver producing a valid/ready word stream with error pulses.
// Define UART_RX_FIFO_EN to replace the single holding register with a FIFO_DEPTH-entry FIFO.
module uart_rx_param #(
   parameter int CLKS_PER_BIT = 10417,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_MODE  = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 uart_rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_par_err,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] CNT_LAST      = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF      = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [IW-1:0] IDX_LAST_DATA = IW'(DATA_BITS - 1);
   localparam logic [IW-1:0] IDX_LAST_STOP = IW'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } state_t;

   generate
      if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
          STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
      begin : g_bad_param
         $error("uart_rx_param: illegal parameter value");
      end
   endgenerate

   function automatic logic calc_par_err(input logic [DATA_BITS-1:0] data, input logic par_bit);
      calc_par_err = ((^data) ^ par_bit) != (PARITY_MODE == 2);
   endfunction

   logic                 sync_r, line_r;
   state_t               state_r, state_nxt;
   logic [CW-1:0]        cnt_r, cnt_nxt;
   logic [IW-1:0]        idx_r, idx_nxt;
   logic [DATA_BITS-1:0] shift_r, shift_nxt;
   logic                 perr_r, perr_nxt;
   logic                 deliver_r, deliver_nxt;
   logic                 ferr_r, ferr_nxt;
   logic                 busy_r;
   logic                 sample_s;

   // two-flop synchroniser for the asynchronous serial line
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_r <= 1'b1;
         line_r <= 1'b1;
      end else begin
         sync_r <= uart_rx;
         line_r <= sync_r;
      end
   end

   // frame FSM: next state, counters and shift register
   always_comb begin
      state_nxt   = state_r;
      cnt_nxt     = cnt_r;
      idx_nxt     = idx_r;
      shift_nxt   = shift_r;
      perr_nxt    = perr_r;
      deliver_nxt = 1'b0;
      ferr_nxt    = 1'b0;
      sample_s    = (cnt_r == CNT_LAST);
      case (state_r)
         ST_IDLE: begin
            cnt_nxt = '0;
            idx_nxt = '0;
            if (!line_r) state_nxt = ST_START;
            else         state_nxt = ST_IDLE;
         end
         ST_START: begin
            if (cnt_r == CNT_HALF) begin
               cnt_nxt = '0;
               if (!line_r) begin
                  state_nxt = ST_DATA;
                  idx_nxt   = '0;
                  perr_nxt  = 1'b0;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end else begin
               cnt_nxt = cnt_r + CW'(1'b1);
            end
         end
         ST_DATA: begin
            if (sample_s) begin
               cnt_nxt   = '0;
               // shifting in at the MSB leaves the first wire bit in bit 0 once the word is complete
               shift_nxt = {line_r, shift_r[DATA_BITS-1:1]};
               if (idx_r == IDX_LAST_DATA) begin
                  idx_nxt   = '0;
                  state_nxt = (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;
               end else begin
                  idx_nxt = idx_r + IW'(1'b1);
               end
            end else begin
               cnt_nxt = cnt_r + CW'(1'b1);
            end
         end
         ST_PARITY: begin
            if (sample_s) begin
               cnt_nxt   = '0;
               idx_nxt   = '0;
               perr_nxt  = calc_par_err(shift_r, line_r);
               state_nxt = ST_STOP;
            end else begin
               cnt_nxt = cnt_r + CW'(1'b1);
            end
         end
         ST_STOP: begin
            if (sample_s) begin
               cnt_nxt = '0;
               if (!line_r) begin
                  ferr_nxt  = 1'b1;
                  state_nxt = ST_BREAK;
               end else if (idx_r == IDX_LAST_STOP) begin
                  deliver_nxt = 1'b1;
                  state_nxt   = ST_IDLE;
               end else begin
                  idx_nxt = idx_r + IW'(1'b1);
               end
            end else begin
               cnt_nxt = cnt_r + CW'(1'b1);
            end
         end
         ST_BREAK: begin
            cnt_nxt = '0;
            idx_nxt = '0;
            if (line_r) state_nxt = ST_IDLE;
            else        state_nxt = ST_BREAK;
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
         end
      endcase
   end

   // frame FSM state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= ST_IDLE;
         cnt_r     <= '0;
         idx_r     <= '0;
         shift_r   <= '0;
         perr_r    <= 1'b0;
         deliver_r <= 1'b0;
         ferr_r    <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_nxt;
         cnt_r     <= cnt_nxt;
         idx_r     <= idx_nxt;
         shift_r   <= shift_nxt;
         perr_r    <= perr_nxt;
         deliver_r <= deliver_nxt;
         ferr_r    <= ferr_nxt;
         busy_r    <= (state_nxt != ST_IDLE);
      end
   end

   assign frame_err = ferr_r;
   assign busy      = busy_r;

   logic [DATA_BITS-1:0] data_r;
   logic                 out_perr_r;
   logic                 valid_r;
   logic                 ovr_r;
   logic                 pop_s;

   assign pop_s = valid_r & rx_ready;

`ifdef UART_RX_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_BITS:0] mem_r [FIFO_DEPTH];
   logic [AW:0]        wr_ptr_r, rd_ptr_r, wr_nxt_s, rd_nxt_s;
   logic               full_s, push_s;
   logic [DATA_BITS:0] new_s, head_s;

   assign new_s    = {perr_r, shift_r};
   assign full_s   = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign push_s   = deliver_r & (~full_s | pop_s);
   assign wr_nxt_s = push_s ? (wr_ptr_r + (AW+1)'(1'b1)) : wr_ptr_r;
   assign rd_nxt_s = pop_s  ? (rd_ptr_r + (AW+1)'(1'b1)) : rd_ptr_r;
   // a word pushed into an empty FIFO is forwarded straight to the output register
   assign head_s   = (push_s && (rd_nxt_s == wr_ptr_r)) ? new_s : mem_r[rd_nxt_s[AW-1:0]];

   // FIFO storage, pointers and registered head entry
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= '0;
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         data_r     <= '0;
         out_perr_r <= 1'b0;
         valid_r    <= 1'b0;
         ovr_r      <= 1'b0;
      end else begin
         if (push_s) mem_r[wr_ptr_r[AW-1:0]] <= new_s;
         wr_ptr_r <= wr_nxt_s;
         rd_ptr_r <= rd_nxt_s;
         valid_r  <= (wr_nxt_s != rd_nxt_s);
         ovr_r    <= deliver_r & full_s & ~pop_s;
         if (wr_nxt_s != rd_nxt_s) begin
            data_r     <= head_s[DATA_BITS-1:0];
            out_perr_r <= head_s[DATA_BITS];
         end
      end
   end
`else
   // single holding register behind rx_valid
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         data_r     <= '0;
         out_perr_r <= 1'b0;
         valid_r    <= 1'b0;
         ovr_r      <= 1'b0;
      end else begin
         ovr_r <= 1'b0;
         if (deliver_r && (!valid_r || pop_s)) begin
            data_r     <= shift_r;
            out_perr_r <= perr_r;
            valid_r    <= 1'b1;
         end else if (deliver_r) begin
            ovr_r <= 1'b1;
         end else if (pop_s) begin
            valid_r <= 1'b0;
         end
      end
   end
`endif

   assign rx_data    = data_r;
   assign rx_par_err = out_perr_r;
   assign rx_valid   = valid_r;
   assign overrun    = ovr_r;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed + randomised bench for uart_rx_param: one 8N1 instance and one even-parity, 2-stop instance.
module tb_uart_rx_param;
   localparam int CPB = 16;
`ifdef UART_RX_FIFO_EN
   localparam int CAP = 4;
`else
   localparam int CAP = 1;
`endif

   logic clk = 1'b0;
   logic reset_n;
   logic line0, rdy0, perr0, v0, fe0, ov0, busy0;
   logic line1, rdy1, perr1, v1, fe1, ov1, busy1;
   logic [7:0] data0, data1;

   always #5 clk = ~clk;

   uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
      .clock(clk), .reset_n(reset_n), .uart_rx(line0), .rx_data(data0), .rx_par_err(perr0),
      .rx_valid(v0), .rx_ready(rdy0), .frame_err(fe0), .overrun(ov0), .busy(busy0));

   uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut1 (
      .clock(clk), .reset_n(reset_n), .uart_rx(line1), .rx_data(data1), .rx_par_err(perr1),
      .rx_valid(v1), .rx_ready(rdy1), .frame_err(fe1), .overrun(ov1), .busy(busy1));

   logic [8:0] got0[$];
   logic [8:0] got1[$];
   int fe_cnt0 = 0, ov_cnt0 = 0, fe_cnt1 = 0, ov_cnt1 = 0;
   int compared = 0, mismatched = 0;

   // accepted-word and pulse monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (reset_n) begin
         if (v0 && rdy0) got0.push_back({perr0, data0});
         if (v1 && rdy1) got1.push_back({perr1, data1});
         if (fe0) fe_cnt0 <= fe_cnt0 + 1;
         if (ov0) ov_cnt0 <= ov_cnt0 + 1;
         if (fe1) fe_cnt1 <= fe_cnt1 + 1;
         if (ov1) ov_cnt1 <= ov_cnt1 + 1;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] frm0(input logic [7:0] d, input logic stop);
      frm0 = {6'b0, stop, d, 1'b0};
   endfunction

   function automatic logic [15:0] frm1(input logic [7:0] d, input logic p, input logic stop2);
      frm1 = {4'b0, stop2, 1'b1, p, d, 1'b0};
   endfunction

   // bits are sent LSB first, each held for one bit time; the line is left idle-high
   task automatic send(input bit sel, input logic [15:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         if (sel) line1 = bits[i];
         else     line0 = bits[i];
         repeat (CPB) @(posedge clk);
         #1;
      end
      if (sel) line1 = 1'b1;
      else     line0 = 1'b1;
   endtask

   task automatic wait_words(input bit sel, input int n);
      int k;
      k = 0;
      while (((sel ? got1.size() : got0.size()) < n) && (k < 4000)) begin
         @(posedge clk);
         k++;
      end
      #1;
      check("wait_word", ((sel ? got1.size() : got0.size()) >= n), 1);
   endtask

   logic [8:0] exp_q[$];
   logic [8:0] store_q[$];
   logic [7:0] d;
   logic       p;
   int base, fe_base, ov_base, exp_ovr;

   initial begin
      line0 = 1'b1; line1 = 1'b1; rdy0 = 1'b1; rdy1 = 1'b1; reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_data0", data0, 0);
      check("rst_valid0", v0, 0);
      check("rst_perr0", perr0, 0);
      check("rst_fe0", fe0, 0);
      check("rst_ov0", ov0, 0);
      check("rst_busy0", busy0, 0);
      check("rst_valid1", v1, 0);
      check("rst_busy1", busy1, 0);
      reset_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // plain 8N1 words with the consumer always ready
      exp_q = {};
      for (int i = 0; i < 6; i++) begin
         d = (i == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
         exp_q.push_back({1'b0, d});
         send(1'b0, frm0(d, 1'b1), 10);
      end
      wait_words(1'b0, 6);
      repeat (20) @(posedge clk);
      #1;
      check("t1_count", got0.size(), 6);
      for (int i = 0; i < 6; i++) check("t1_word", got0[i], exp_q[i]);
      check("t1_fe", fe_cnt0, 0);
      check("t1_ov", ov_cnt0, 0);

      // even parity with two stop bits on the second instance
      exp_q = {};
      for (int i = 0; i < 6; i++) begin
         d = (i < 2) ? 8'h03 : 8'($urandom_range(0, 255));
         p = (i == 0) ? 1'b1 : (i == 1) ? 1'b0 : 1'($urandom_range(0, 1));
         exp_q.push_back({($countones({d, p}) % 2 == 1), d});
         send(1'b1, frm1(d, p, 1'b1), 12);
      end
      wait_words(1'b1, 6);
      repeat (20) @(posedge clk);
      #1;
      check("t2_count", got1.size(), 6);
      for (int i = 0; i < 6; i++) check("t2_word", got1[i], exp_q[i]);
      send(1'b1, frm1(8'h5A, 1'b0, 1'b0), 12);
      repeat (20) @(posedge clk);
      #1;
      check("t2_stop2_fe", fe_cnt1, 1);
      check("t2_stop2_noword", got1.size(), 6);

      // stop bit low followed by a long break
      base = got0.size(); fe_base = fe_cnt0;
      send(1'b0, frm0(8'h55, 1'b0), 10);
      line0 = 1'b0;
      repeat (40 * CPB) @(posedge clk);
      #1;
      check("t3_fe_once", fe_cnt0 - fe_base, 1);
      check("t3_busy_break", busy0, 1);
      check("t3_no_valid", v0, 0);
      line0 = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("t3_busy_idle", busy0, 0);
      check("t3_noword", got0.size(), base);

      // short low glitch must not start a frame
      line0 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("t4_busy_start", busy0, 1);
      repeat (4) @(posedge clk);
      #1;
      line0 = 1'b1;
      repeat (3 * CPB) @(posedge clk);
      #1;
      check("t4_busy_idle", busy0, 0);
      check("t4_noword", got0.size(), base);
      check("t4_nofe", fe_cnt0 - fe_base, 1);

      // overrun with a stalled consumer, then drain in order
      rdy0 = 1'b0; store_q = {}; exp_ovr = 0; ov_base = ov_cnt0;
      for (int i = 0; i < 6; i++) begin
         d = (i == 0) ? 8'h11 : (i == 1) ? 8'h22 : 8'($urandom_range(0, 255));
         if (store_q.size() < CAP) store_q.push_back({1'b0, d});
         else exp_ovr++;
         send(1'b0, frm0(d, 1'b1), 10);
      end
      repeat (50) @(posedge clk);
      #1;
      check("t5_overruns", ov_cnt0 - ov_base, exp_ovr);
      check("t5_valid_held", v0, 1);
      check("t5_head", {perr0, data0}, store_q[0]);
      rdy0 = 1'b1;
      wait_words(1'b0, base + store_q.size());
      repeat (10) @(posedge clk);
      #1;
      check("t5_drain_count", got0.size(), base + store_q.size());
      for (int i = 0; i < store_q.size(); i++) check("t5_drain_word", got0[base + i], store_q[i]);
      check("t5_empty", v0, 0);

      // reset in the middle of a data phase
      send(1'b0, frm0(8'hF0, 1'b1), 4);
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("t6_rst_data", data0, 0);
      check("t6_rst_valid", v0, 0);
      check("t6_rst_busy", busy0, 0);
      check("t6_rst_fe", fe0, 0);
      check("t6_rst_ov", ov0, 0);
      reset_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      base = got0.size(); fe_base = fe_cnt0; ov_base = ov_cnt0;
      send(1'b0, frm0(8'h0F, 1'b1), 10);
      wait_words(1'b0, base + 1);
      repeat (40) @(posedge clk);
      #1;
      check("t6_count", got0.size(), base + 1);
      check("t6_word", got0[base], {1'b0, 8'h0F});
      check("t6_nofe", fe_cnt0, fe_base);
      check("t6_noov", ov_cnt0, ov_base);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
